// File: rtl/miriscv_lsu_if.sv
// Purpose : bundles of the LSU core-side and memory-side signals.
// Latency : n/a (signal bundles only).
// Backpressure: core side stalls on lsu_stall_req_o; memory side completes on data_rvalid_i.
//
// miriscv_lsu_core_if : decoder/ALU request in, stall/result/error out.
//    master = core pipeline, slave = LSU.
// miriscv_lsu_mem_if  : word-addressed data memory port.
//    master = LSU, slave = data memory.

interface miriscv_lsu_core_if;
   logic        lsu_req_i;
   logic        lsu_we_i;
   logic [2:0]  lsu_size_i;
   logic [31:0] lsu_addr_i;
   logic [31:0] lsu_data_i;
   logic        lsu_stall_req_o;
   logic [31:0] lsu_data_o;
   logic        lsu_err_o;

   modport master (
      output lsu_req_i, lsu_we_i, lsu_size_i, lsu_addr_i, lsu_data_i,
      input  lsu_stall_req_o, lsu_data_o, lsu_err_o
   );
   modport slave (
      input  lsu_req_i, lsu_we_i, lsu_size_i, lsu_addr_i, lsu_data_i,
      output lsu_stall_req_o, lsu_data_o, lsu_err_o
   );
endinterface

interface miriscv_lsu_mem_if;
   logic        data_req_o;
   logic        data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_addr_o;
   logic [31:0] data_wdata_o;
   logic        data_rvalid_i;
   logic [31:0] data_rdata_i;

   modport master (
      output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
      input  data_rvalid_i, data_rdata_i
   );
   modport slave (
      input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
      output data_rvalid_i, data_rdata_i
   );
endinterface

// File: rtl/miriscv_lsu.sv
// Purpose : miriscv load/store unit, one access at a time on a word-addressed data port.
// Latency : 3 cycles with zero-wait memory (IDLE, BUSY, DONE), +1 per wait cycle; illegal access 2 cycles.
// Backpressure: holds the core via combinational lsu_stall_req_o until DONE; waits on data_rvalid_i in BUSY.
//
// Ports:
//    clk_i, rst_i : clock (rising edge), synchronous active-high reset
//    core         : request (req/we/size/addr/data), stall, extended load result, error pulse
//    mem          : req/we/be/addr/wdata out, rvalid/rdata in

module miriscv_lsu (
   input  logic                    clk_i,
   input  logic                    rst_i,
   miriscv_lsu_core_if.slave       core,
   miriscv_lsu_mem_if.master       mem
);

   localparam logic [2:0] LDST_B  = 3'd0;
   localparam logic [2:0] LDST_H  = 3'd1;
   localparam logic [2:0] LDST_W  = 3'd2;
   localparam logic [2:0] LDST_BU = 3'd4;
   localparam logic [2:0] LDST_HU = 3'd5;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state;
   logic [2:0]  size_q;
   logic [1:0]  off_q;
   logic        req_q;
   logic        we_q;
   logic [3:0]  be_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic        legal;
   logic [3:0]  be_nxt;
   logic [31:0] wdata_nxt;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_ext;

   // Legality of the request as presented in IDLE.
   always_comb begin
      legal = 1'b0;
      case (core.lsu_size_i)
         LDST_B:  legal = 1'b1;
         LDST_H:  legal = ~core.lsu_addr_i[0];
         LDST_W:  legal = (core.lsu_addr_i[1:0] == 2'b00);
         LDST_BU: legal = ~core.lsu_we_i;
         LDST_HU: legal = ~core.lsu_we_i & ~core.lsu_addr_i[0];
         default: legal = 1'b0;
      endcase
   end

   // Store data is replicated across lanes so the byte enables alone pick the target bytes.
   always_comb begin
      be_nxt    = 4'b1111;
      wdata_nxt = 32'h0;
      if (core.lsu_we_i) begin
         case (core.lsu_size_i)
            LDST_B: begin
               be_nxt    = 4'b0001 << core.lsu_addr_i[1:0];
               wdata_nxt = {4{core.lsu_data_i[7:0]}};
            end
            LDST_H: begin
               be_nxt    = core.lsu_addr_i[1] ? 4'b1100 : 4'b0011;
               wdata_nxt = {2{core.lsu_data_i[15:0]}};
            end
            default: begin
               be_nxt    = 4'b1111;
               wdata_nxt = core.lsu_data_i;
            end
         endcase
      end
   end

   // Load lane extraction uses the offset latched in IDLE, not the live address.
   always_comb begin
      ld_byte = mem.data_rdata_i[{off_q, 3'b000} +: 8];
      ld_half = mem.data_rdata_i[{off_q[1], 4'b0000} +: 16];
      case (size_q)
         LDST_B:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         LDST_BU: ld_ext = {24'h0, ld_byte};
         LDST_H:  ld_ext = {{16{ld_half[15]}}, ld_half};
         LDST_HU: ld_ext = {16'h0, ld_half};
         default: ld_ext = mem.data_rdata_i;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= IDLE;
         size_q  <= 3'd0;
         off_q   <= 2'd0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         be_q    <= 4'd0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (core.lsu_req_i) begin
                  if (legal) begin
                     size_q  <= core.lsu_size_i;
                     off_q   <= core.lsu_addr_i[1:0];
                     we_q    <= core.lsu_we_i;
                     be_q    <= be_nxt;
                     addr_q  <= {core.lsu_addr_i[31:2], 2'b00};
                     wdata_q <= wdata_nxt;
                     req_q   <= 1'b1;
                     state   <= BUSY;
                  end else begin
                     // No memory access; only an errored load clears the result.
                     err_q <= 1'b1;
                     if (!core.lsu_we_i)
                        rdata_q <= 32'h0;
                     state <= DONE;
                  end
               end
            end
            BUSY: begin
               if (mem.data_rvalid_i) begin
                  req_q <= 1'b0;
                  if (!we_q)
                     rdata_q <= ld_ext;
                  state <= DONE;
               end
            end
            DONE: begin
               err_q <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign core.lsu_stall_req_o = ~rst_i &
                                 (((state == IDLE) & core.lsu_req_i) | (state == BUSY));
   assign core.lsu_data_o      = rdata_q;
   assign core.lsu_err_o       = err_q;

   assign mem.data_req_o   = req_q;
   assign mem.data_we_o    = we_q;
   assign mem.data_be_o    = be_q;
   assign mem.data_addr_o  = addr_q;
   assign mem.data_wdata_o = wdata_q;

endmodule
